// File: rtl/ins_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/valid memory handshake and
// presents {instruction, p_count} to the parser; branch/jump resolution on accept picks the next PC.
module ins_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_instruction,
    output logic [31:0] o_p_count,
    input  logic        i_br_taken,
    input  logic [15:0] i_br_imm,
    input  logic        i_jump,
    input  logic [25:0] i_jaddr,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_fetch_err
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t           r_state,       w_state_nxt;
    logic [31:0]      r_pc,          w_pc_nxt;
    logic             r_drop,        w_drop_nxt;
    logic [CNT_W-1:0] r_wait_cnt,    w_wait_cnt_nxt;
    logic             r_imem_req,    w_imem_req_nxt;
    logic [31:0]      r_imem_addr,   w_imem_addr_nxt;
    logic             r_out_valid,   w_out_valid_nxt;
    logic [31:0]      r_instruction, w_instruction_nxt;
    logic [31:0]      r_p_count,     w_p_count_nxt;
    logic             r_fetch_err,   w_fetch_err_nxt;

    logic [31:0]      w_pc4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_next_pc;
    logic             w_stale_rsp;

    // Next sequential PC from the instruction being accepted; jump wins over branch.
    assign w_pc4     = r_p_count + 32'd4;
    assign w_br_off  = {{14{i_br_imm[15]}}, i_br_imm, 2'b00};
    assign w_next_pc = i_jump     ? {w_pc4[31:28], i_jaddr, 2'b00} :
                       i_br_taken ? w_pc4 + w_br_off : w_pc4;
    assign w_stale_rsp = i_imem_valid && r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_wait_cnt    <= '0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_out_valid   <= 1'b0;
            r_instruction <= '0;
            r_p_count     <= '0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_imem_addr   <= w_imem_addr_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_instruction <= w_instruction_nxt;
            r_p_count     <= w_p_count_nxt;
            r_fetch_err   <= w_fetch_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_nxt        = r_drop;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_imem_req_nxt    = 1'b0;
        w_imem_addr_nxt   = r_imem_addr;
        w_out_valid_nxt   = r_out_valid;
        w_instruction_nxt = r_instruction;
        w_p_count_nxt     = r_p_count;
        w_fetch_err_nxt   = r_fetch_err;

        case (r_state)
            S_FETCH: begin
                w_imem_req_nxt  = 1'b1;
                w_imem_addr_nxt = r_pc;
                w_wait_cnt_nxt  = '0;
                w_state_nxt     = S_WAIT;
                if (w_stale_rsp) begin
                    w_drop_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (w_stale_rsp) begin
                    // Replacement request is already in flight; keep waiting for it.
                    w_drop_nxt     = 1'b0;
                    w_wait_cnt_nxt = '0;
                end else if (i_imem_valid) begin
                    w_instruction_nxt = i_imem_rdata;
                    w_p_count_nxt     = r_pc;
                    w_out_valid_nxt   = 1'b1;
                    w_state_nxt       = S_HOLD;
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_fetch_err_nxt = 1'b1;
                    w_state_nxt     = S_ERR;
                end else begin
                    w_wait_cnt_nxt = CNT_W'(r_wait_cnt + CNT_W'(1));
                end
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_pc_nxt        = w_next_pc;
                    w_state_nxt     = S_FETCH;
                end
            end
            S_ERR: begin
                w_out_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase

        // Redirect overrides everything except the terminal error state.
        if (i_flush && (r_state != S_ERR)) begin
            w_pc_nxt        = i_flush_pc & ~32'd3;
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_FETCH;
            w_drop_nxt      = (r_state == S_FETCH) ||
                              ((r_state == S_WAIT) && (!i_imem_valid || r_drop));
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_out_valid   = r_out_valid;
    assign o_instruction = r_instruction;
    assign o_p_count     = r_p_count;
    assign o_fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: in-order latency memory, transaction-level PC model checked every cycle,
// plus directed scenarios with literal expected addresses.
module tb_ins_fetch;

    localparam int unsigned T   = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_instruction;
    logic [31:0] o_p_count;
    logic        i_br_taken;
    logic [15:0] i_br_imm;
    logic        i_jump;
    logic [25:0] i_jaddr;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_fetch_err;

    ins_fetch #(.RESET_PC(RPC), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_instruction(o_instruction), .o_p_count(o_p_count),
        .i_br_taken(i_br_taken), .i_br_imm(i_br_imm),
        .i_jump(i_jump), .i_jaddr(i_jaddr),
        .i_flush(i_flush), .i_flush_pc(i_flush_pc),
        .o_fetch_err(o_fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cycle     = 0;
    int          last_due  = 0;
    int          force_lat = 0;
    bit          mute      = 1'b0;
    bit          fflush    = 1'b0;
    logic [31:0] last_req_addr = '0;
    int          n_chk = 0;
    int          n_err = 0;

    // Model state: address the next fetch/presentation must carry.
    logic [31:0] m_pc = RPC;
    bit          m_held = 1'b0;
    bit          m_stale = 1'b0;
    logic [31:0] m_stale_pc = '0;
    logic [31:0] h_pc = '0;
    logic [31:0] h_ins = '0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                               input logic [15:0] imm, input logic j,
                                               input logic [25:0] ja);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) | (32'(ja) << 2);
        if (br) return pc4 + 32'(int'($signed(imm)) * 4);
        return pc4;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // One clock: advance, then act as the memory for the new cycle.
    task automatic tick();
        int lat;
        @(posedge clk);
        #1;
        cycle++;
        if (reset) begin
            mq.delete();
            i_imem_valid = 1'b0;
            return;
        end
        if (o_imem_req) begin
            lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
            last_due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
            mq.push_back('{addr: o_imem_addr, due: last_due});
            last_req_addr = o_imem_addr;
        end
        if (!mute && mq.size() > 0 && mq[0].due <= cycle) begin
            i_imem_valid = 1'b1;
            i_imem_rdata = memword(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            i_imem_valid = 1'b0;
            i_imem_rdata = $urandom;
        end
    endtask

    task automatic wait_present(output logic [31:0] pc, output logic [31:0] ins);
        bit seen = 1'b0;
        pc = '0;
        ins = '0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (o_out_valid) begin
                seen = 1'b1;
                pc = o_p_count;
                ins = o_instruction;
                break;
            end
        end
        check("present_timeout", 32'(seen), 32'd1);
    endtask

    task automatic present_at(input logic [31:0] want);
        logic [31:0] pc, ins;
        bit found = 1'b0;
        for (int k = 0; k < 24; k++) begin
            wait_present(pc, ins);
            if (pc == want) begin
                found = 1'b1;
                break;
            end
        end
        check("present_at_reached", 32'(found), 32'd1);
    endtask

    task automatic wait_req(output logic [31:0] addr);
        bit seen = 1'b0;
        addr = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_imem_req) begin
                seen = 1'b1;
                addr = o_imem_addr;
                break;
            end
        end
        check("req_timeout", 32'(seen), 32'd1);
    endtask

    // Every-cycle comparison against the transaction-level model.
    always @(negedge clk) begin
        if (reset) begin
            m_pc    = RPC;
            m_held  = 1'b0;
            m_stale = 1'b0;
        end else begin
            if (!mute) check("fetch_err_low", 32'(o_fetch_err), 32'd0);
            if (o_imem_req) begin
                check("req_during_valid", 32'(o_out_valid), 32'd0);
                check("imem_addr", o_imem_addr, m_stale ? m_stale_pc : m_pc);
                m_stale = 1'b0;
            end
            if (o_out_valid) begin
                if (!m_held) begin
                    check("p_count", o_p_count, m_pc);
                    check("instruction", o_instruction, memword(m_pc));
                end else begin
                    check("hold_p_count", o_p_count, h_pc);
                    check("hold_instruction", o_instruction, h_ins);
                end
                m_held = 1'b1;
                h_pc   = o_p_count;
                h_ins  = o_instruction;
                if (i_out_ready && !i_flush) begin
                    m_pc   = model_next(m_pc, i_br_taken, i_br_imm, i_jump, i_jaddr);
                    m_held = 1'b0;
                end
            end else begin
                m_held = 1'b0;
            end
            if (i_flush && !o_fetch_err) begin
                if (fflush) begin
                    m_stale    = 1'b1;
                    m_stale_pc = m_pc;
                end
                m_pc   = i_flush_pc & ~32'd3;
                m_held = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, ins, addr;
        int c_req, n_pres;
        reset = 1'b1; i_imem_valid = 1'b0; i_imem_rdata = '0; i_out_ready = 1'b1;
        i_br_taken = 1'b0; i_br_imm = '0; i_jump = 1'b0; i_jaddr = '0;
        i_flush = 1'b0; i_flush_pc = '0;
        tick(); tick();
        check("rst_imem_req", 32'(o_imem_req), 32'd0);
        check("rst_imem_addr", o_imem_addr, 32'd0);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_instruction", o_instruction, 32'd0);
        check("rst_p_count", o_p_count, 32'd0);
        check("rst_fetch_err", 32'(o_fetch_err), 32'd0);
        reset = 1'b0;

        // Sequential fetch with latency 1.
        force_lat = 1;
        for (int k = 0; k < 3; k++) begin
            wait_present(pc, ins);
            check("t1_req_addr", last_req_addr, 32'(k * 4));
            check("t1_p_count", pc, 32'(k * 4));
            check("t1_word", ins, memword(32'(k * 4)));
        end
        force_lat = 0;

        // Backward then forward branch from 0x10.
        present_at(32'h10);
        i_br_taken = 1'b1; i_br_imm = 16'hFFFC;
        tick();
        i_br_taken = 1'b0;
        wait_req(addr);
        check("t2_back_branch", addr, 32'h0000_0004);
        present_at(32'h10);
        i_br_taken = 1'b1; i_br_imm = 16'h0003;
        tick();
        i_br_taken = 1'b0;
        wait_req(addr);
        check("t2_fwd_branch", addr, 32'h0000_0020);

        // Jump beats branch; flush target low bits are cleared.
        wait_present(pc, ins);
        i_flush = 1'b1; i_flush_pc = 32'h3000_000B;
        tick();
        i_flush = 1'b0;
        wait_present(pc, ins);
        check("t3_flush_pc", pc, 32'h3000_0008);
        i_jump = 1'b1; i_jaddr = 26'h000_0040; i_br_taken = 1'b1; i_br_imm = 16'h1234;
        tick();
        i_jump = 1'b0; i_br_taken = 1'b0;
        wait_req(addr);
        check("t3_jump", addr, 32'h3000_0100);

        // Back-pressure: output held, no fetch while stalled.
        wait_present(pc, ins);
        i_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_valid_held", 32'(o_out_valid), 32'd1);
            check("t4_no_req", 32'(o_imem_req), 32'd0);
        end
        check("t4_p_count_held", o_p_count, pc);
        i_out_ready = 1'b1;
        wait_req(addr);
        check("t4_resume", addr, pc + 32'd4);

        // Flush while waiting: the older response must be discarded.
        wait_present(pc, ins);
        force_lat = 3;
        wait_req(addr);
        force_lat = 2;
        i_flush = 1'b1; i_flush_pc = 32'h0000_0200;
        tick();
        i_flush = 1'b0;
        wait_present(pc, ins);
        check("t5_p_count", pc, 32'h0000_0200);
        check("t5_word", ins, memword(32'h0000_0200));
        force_lat = 0;

        // Flush in the fetch cycle right after an accept.
        wait_present(pc, ins);
        tick();
        fflush = 1'b1; i_flush = 1'b1; i_flush_pc = 32'h0000_1000;
        tick();
        fflush = 1'b0; i_flush = 1'b0;
        wait_present(pc, ins);
        check("t_fetch_flush_pc", pc, 32'h0000_1000);
        check("t_fetch_flush_word", ins, memword(32'h0000_1000));

        // Randomized traffic.
        n_pres = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (o_out_valid && i_out_ready) n_pres++;
            i_out_ready = ($urandom_range(0, 9) < 7);
            i_br_taken  = $urandom_range(0, 1) == 1;
            i_br_imm    = 16'($urandom);
            i_jump      = $urandom_range(0, 3) == 0;
            i_jaddr     = 26'($urandom);
            i_flush_pc  = $urandom;
            i_flush     = (($urandom_range(0, 14) == 0) &&
                           ((o_out_valid && mq.size() == 0) || (o_imem_req && mq.size() == 1)));
        end
        i_flush = 1'b0; i_out_ready = 1'b1; i_br_taken = 1'b0; i_jump = 1'b0;
        check("rand_progress", 32'(n_pres >= 20), 32'd1);

        // Memory timeout: sticky error exactly TIMEOUT_CYC cycles after the request.
        wait_present(pc, ins);
        mute = 1'b1;
        wait_req(addr);
        c_req = cycle;
        for (int k = 0; k < 40 && !o_fetch_err; k++) tick();
        check("t6_err_set", 32'(o_fetch_err), 32'd1);
        check("t6_err_latency", 32'(cycle - c_req), 32'(T));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_err_no_req", 32'(o_imem_req), 32'd0);
            check("t6_err_no_valid", 32'(o_out_valid), 32'd0);
            check("t6_err_sticky", 32'(o_fetch_err), 32'd1);
        end
        reset = 1'b1;
        tick(); tick();
        check("t6_err_cleared", 32'(o_fetch_err), 32'd0);
        reset = 1'b0;
        mute = 1'b0;
        wait_present(pc, ins);
        check("t6_restart_pc", pc, RPC);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
